// File: rtl/moving_avg_scheduler.sv
// rtl/moving_avg_scheduler.sv - round-robin scheduler sharing one moving-average datapath across channels
// Per-channel sum/pointer/full state; a single delay-line memory holds one window per channel.
module moving_avg_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int WINDOW_SHIFT = 4,
    parameter int CH_SHIFT     = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [(2**CH_SHIFT)*DATA_WIDTH-1:0]   in_data,
    input  logic [(2**CH_SHIFT)-1:0]              in_valid,
    output logic [(2**CH_SHIFT)-1:0]              in_ready,
    input  logic [(2**CH_SHIFT)-1:0]              ch_clear,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic [CH_SHIFT-1:0]                   out_channel,
    output logic                                  out_valid
);

    localparam int NUM_CH      = 2**CH_SHIFT;
    localparam int WINDOW_SIZE = 2**WINDOW_SHIFT;
    localparam int SUM_W       = DATA_WIDTH + WINDOW_SHIFT;
    localparam logic [WINDOW_SHIFT-1:0] PTR_LAST = '1;
    localparam logic [CH_SHIFT-1:0]     CH_LAST  = '1;

    logic [CH_SHIFT-1:0]           last_grant;
    logic [NUM_CH-1:0]             cand;
    logic [CH_SHIFT-1:0]           grant_ch;
    logic [CH_SHIFT-1:0]           idx;
    logic                          grant_valid;

    logic signed [SUM_W-1:0]       sum_q [NUM_CH];
    logic [WINDOW_SHIFT-1:0]       ptr_q [NUM_CH];
    logic [NUM_CH-1:0]             full_q;

    logic [DATA_WIDTH-1:0]         mem [NUM_CH*WINDOW_SIZE];
    logic [DATA_WIDTH-1:0]         rd_data;

    logic [DATA_WIDTH-1:0]         gnt_data;
    logic [WINDOW_SHIFT-1:0]       gnt_ptr;
    logic                          gnt_last;

    logic                          s1_valid;
    logic [CH_SHIFT-1:0]           s1_ch;
    logic [WINDOW_SHIFT-1:0]       s1_ptr;
    logic [DATA_WIDTH-1:0]         s1_data;
    logic                          s1_full;
    logic                          s1_emit;
    logic                          s1_commit;

    logic                          s2_valid;
    logic [CH_SHIFT-1:0]           s2_ch;
    logic [DATA_WIDTH-1:0]         s2_avg;
    logic                          s2_emit;
    logic                          s2_commit;

    logic signed [SUM_W-1:0]       new_ext;
    logic signed [SUM_W-1:0]       old_ext;
    logic signed [SUM_W-1:0]       new_sum;
    logic [DATA_WIDTH-1:0]         avg_next;

    // Rotating-priority search starting just after the last granted channel.
    always_comb begin
        cand        = in_valid & ~ch_clear & {NUM_CH{enable & ~reset}};
        grant_valid = 1'b0;
        grant_ch    = '0;
        idx         = '0;
        in_ready    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last_grant + CH_SHIFT'(i);
            if (!grant_valid && cand[idx]) begin
                grant_valid = 1'b1;
                grant_ch    = idx;
            end
        end
        if (grant_valid) begin
            in_ready[grant_ch] = 1'b1;
        end
    end

    assign gnt_ptr   = ptr_q[grant_ch];
    assign gnt_data  = in_data[int'(grant_ch)*DATA_WIDTH +: DATA_WIDTH];
    assign gnt_last  = (gnt_ptr == PTR_LAST);

    // A clear arriving while a sample is in flight kills that sample.
    assign s1_commit = s1_valid & ~ch_clear[s1_ch];
    assign s2_commit = s2_valid & s2_emit & ~ch_clear[s2_ch];

    assign new_ext  = {{WINDOW_SHIFT{s1_data[DATA_WIDTH-1]}}, s1_data};
    assign old_ext  = s1_full ? {{WINDOW_SHIFT{rd_data[DATA_WIDTH-1]}}, rd_data} : '0;
    assign new_sum  = sum_q[s1_ch] + new_ext - old_ext;
    assign avg_next = DATA_WIDTH'(new_sum >>> WINDOW_SHIFT);

    always_ff @(posedge clock) begin
        if (s1_commit && !reset) begin
            mem[{s1_ch, s1_ptr}] <= s1_data;
        end
        rd_data <= mem[{grant_ch, gnt_ptr}];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c] <= '0;
                ptr_q[c] <= '0;
            end
            full_q      <= '0;
            last_grant  <= CH_LAST;
            s1_valid    <= 1'b0;
            s1_ch       <= '0;
            s1_ptr      <= '0;
            s1_data     <= '0;
            s1_full     <= 1'b0;
            s1_emit     <= 1'b0;
            s2_valid    <= 1'b0;
            s2_ch       <= '0;
            s2_avg      <= '0;
            s2_emit     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
        end else begin
            s1_valid <= grant_valid;
            if (grant_valid) begin
                last_grant      <= grant_ch;
                ptr_q[grant_ch] <= gnt_ptr + WINDOW_SHIFT'(1);
                if (gnt_last) begin
                    full_q[grant_ch] <= 1'b1;
                end
                s1_ch   <= grant_ch;
                s1_ptr  <= gnt_ptr;
                s1_data <= gnt_data;
                s1_full <= full_q[grant_ch];
                s1_emit <= full_q[grant_ch] | gnt_last;
            end

            s2_valid <= s1_commit;
            if (s1_commit) begin
                sum_q[s1_ch] <= new_sum;
                s2_ch        <= s1_ch;
                s2_avg       <= avg_next;
                s2_emit      <= s1_emit;
            end

            out_valid <= s2_commit;
            if (s2_commit) begin
                out_data    <= s2_avg;
                out_channel <= s2_ch;
            end

            // Placed last so a clear overrides any same-cycle state update.
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_clear[c]) begin
                    sum_q[c]  <= '0;
                    ptr_q[c]  <= '0;
                    full_q[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_avg_scheduler.sv
// tb/tb_moving_avg_scheduler.sv - scoreboard bench for moving_avg_scheduler
module tb_moving_avg_scheduler;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  ch_clear;
    logic [15:0] out_data;
    logic [1:0]  out_channel;
    logic        out_valid;

    moving_avg_scheduler #(
        .DATA_WIDTH   (16),
        .WINDOW_SHIFT (4),
        .CH_SHIFT     (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ch_clear    (ch_clear),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid)
    );

    typedef struct {
        int ch;
        int data;
        int cyc;
    } exp_t;

    exp_t               sb[$];
    int                 hist [4][$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 m_last = 3;
    logic               rst_prev = 1'b0;

    logic               drv_rst;
    logic               drv_en;
    logic [3:0]         drv_valid;
    logic [3:0]         drv_clear;
    logic signed [15:0] drv_d [4];

    assign reset    = drv_rst;
    assign enable   = drv_en;
    assign in_valid = drv_valid;
    assign ch_clear = drv_clear;
    assign in_data  = {drv_d[3], drv_d[2], drv_d[1], drv_d[0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] c, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (c[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    // Remove pending results of channel ch (or all when ch < 0) due at or after cycle k.
    task automatic drop(input int ch, input int k);
        exp_t keep[$];
        foreach (sb[i]) begin
            if (!((ch < 0 || sb[i].ch == ch) && sb[i].cyc >= k)) keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic step();
        logic [3:0] cand;
        logic [3:0] exp_rdy;
        int         g;
        int         k;
        int         s;
        @(negedge clock);
        k = cyc + 1;
        if (drv_rst) begin
            check("in_ready_in_reset", int'(in_ready), 0);
            if (rst_prev) begin
                check("reset_out_valid", int'(out_valid), 0);
                check("reset_out_data", int'(out_data), 0);
                check("reset_out_channel", int'(out_channel), 0);
            end
            m_last = 3;
            for (int c = 0; c < 4; c++) hist[c].delete();
            drop(-1, k);
        end else begin
            cand    = drv_valid & ~drv_clear & {4{drv_en}};
            g       = rr(cand, m_last);
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            check("in_ready", int'(in_ready), int'(exp_rdy));
            if (g >= 0) begin
                hist[g].push_back(int'(drv_d[g]));
                if (hist[g].size() > 16) void'(hist[g].pop_front());
                if (hist[g].size() == 16) begin
                    s = 0;
                    foreach (hist[g][j]) s += hist[g][j];
                    sb.push_back('{ch: g, data: (s >>> 4), cyc: k + 2});
                end
                m_last = g;
            end
            for (int c = 0; c < 4; c++) begin
                if (drv_clear[c]) begin
                    hist[c].delete();
                    drop(c, k);
                end
            end
        end
        rst_prev = drv_rst;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (cyc > 0) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missed_output: ch %0d value %0d due cycle %0d, now %0d",
                         sb[0].ch, sb[0].data, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output at cycle %0d: ch %0d value %0d, expected none",
                             cyc, out_channel, $signed(out_data));
                end else begin
                    e = sb.pop_front();
                    check("out_channel", int'(out_channel), e.ch);
                    check("out_data", int'($signed(out_data)), e.data);
                    check("out_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        drv_rst   = 1'b1;
        drv_en    = 1'b1;
        drv_valid = 4'b1111;
        drv_clear = 4'b0000;
        for (int c = 0; c < 4; c++) drv_d[c] = 16'sd0;
        repeat (3) step();
        drv_rst = 1'b0;

        // Single channel constant 100
        drv_valid = 4'b0001;
        drv_d[0]  = 16'sd100;
        repeat (20) step();
        drv_valid = 4'b0000;
        repeat (4) step();

        // All channels, constants 10, 20, -30, 40 from a fresh reset
        drv_rst = 1'b1;
        repeat (2) step();
        drv_rst   = 1'b0;
        drv_d[0]  = 16'sd10;
        drv_d[1]  = 16'sd20;
        drv_d[2]  = -16'sd30;
        drv_d[3]  = 16'sd40;
        drv_valid = 4'b1111;
        repeat (80) step();
        drv_valid = 4'b0000;
        repeat (4) step();

        drv_clear = 4'b1111;
        step();
        drv_clear = 4'b0000;

        // Channel 1 ramp 0..31
        drv_valid = 4'b0010;
        for (int i = 0; i < 32; i++) begin
            drv_d[1] = 16'(i);
            step();
        end

        // Channel 2: fifteen zeros then -1 must floor to -1
        drv_valid = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            drv_d[2] = (i == 15) ? -16'sd1 : 16'sd0;
            step();
        end
        drv_valid = 4'b0000;
        repeat (4) step();

        // Clear channel 3 while it has samples in flight; channel 0 keeps running
        drv_clear = 4'b1000;
        step();
        drv_clear = 4'b0000;
        drv_d[0]  = 16'sd5;
        drv_d[3]  = 16'sd7;
        drv_valid = 4'b1001;
        repeat (40) step();
        drv_clear = 4'b1000;
        step();
        drv_clear = 4'b0000;
        drv_d[3]  = 16'sd50;
        repeat (32) step();

        // Enable dropped for a few cycles with all channels requesting
        drv_valid = 4'b1111;
        repeat (8) step();
        drv_en = 1'b0;
        repeat (3) step();
        drv_en = 1'b1;
        repeat (8) step();

        // Reset with the pipeline busy, then restart from empty
        drv_rst = 1'b1;
        repeat (2) step();
        drv_rst = 1'b0;
        repeat (70) step();
        drv_valid = 4'b0000;
        repeat (5) step();

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/moving_avg_scheduler.md
# moving_avg_scheduler

Round-robin scheduler that shares a single moving-average datapath among NUM_CH independent sample streams. Each channel keeps its own running sum, window pointer and fill state; one delay-line memory is partitioned into per-channel windows. The block sits between multiple ADC/feature front-ends and downstream logic that needs smoothed per-channel values, replacing NUM_CH separate averagers.

## Interface
- DATA_WIDTH, 16, sample width (signed two's complement).
- WINDOW_SHIFT, 4, log2 of window length; WINDOW_SIZE = 2^WINDOW_SHIFT; must be >= 1.
- CH_SHIFT, 2, log2 of channel count; NUM_CH = 2^CH_SHIFT.

- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  when low, no new samples are accepted; in-flight samples still complete.
- in_data  input  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_CH  per-channel sample valid.
- in_ready  output  NUM_CH  one-hot (or zero) grant; transfer when in_valid[c] & in_ready[c].
- ch_clear  input  NUM_CH  per-channel synchronous clear of sum, pointer and full flag.
- out_data  output  DATA_WIDTH  signed windowed average, registered.
- out_channel  output  CH_SHIFT  channel index of out_data.
- out_valid  output  1  one-cycle strobe; no backpressure.

## Operation
- Per-channel state: ptr[c] (WINDOW_SHIFT bits), full[c], sum[c] (DATA_WIDTH+WINDOW_SHIFT bits, signed). Delay-line memory: NUM_CH*WINDOW_SIZE words, address {c, ptr[c]}, synchronous read, one write port.
- Arbitration (combinational in_ready): candidates = in_valid & ~ch_clear, masked to zero when enable low or reset high. Grant highest-priority candidate, priority starting at (last_grant+1) mod NUM_CH. last_grant updates only on a transfer. After reset, channel 0 has highest priority.
- Stage 0 (transfer cycle): latch sample, channel, full[c]; issue memory read at {c, ptr[c]}; ptr[c] <= ptr[c]+1 (wraps modulo WINDOW_SIZE); full[c] <= 1 when ptr[c] == WINDOW_SIZE-1.
- Stage 1: old = memory read data; new_sum = sum[c] + sext(new) - (latched full ? sext(old) : 0); sum[c] <= new_sum; write new sample to {c, ptr_at_stage0}.
- Output register: out_data <= new_sum arithmetic-shifted right by WINDOW_SHIFT (floor toward -inf); out_channel <= c; out_valid <= 1 only if the sample completes or follows a full window (i.e. full[c] after this sample's stage-0 update).
- Sum width DATA_WIDTH+WINDOW_SHIFT: cannot overflow; no saturation.
- Back-to-back same channel: stage 1 of sample k and stage 0 of sample k+1 overlap; sum[c] forwarded so no sample is lost; read and write addresses differ (ptr advanced).
- ch_clear[c]: sum[c], ptr[c], full[c] <= 0 next edge; any in-flight stage-0/stage-1 sample of channel c is discarded (no sum write, no out_valid). Clear wins over a same-cycle transfer (in_ready[c] forced low). Memory contents not cleared; ignored until full.
- Reset: all per-channel state zero, pipeline emptied, last_grant = NUM_CH-1, out_data = 0, out_channel = 0, out_valid = 0, in_ready = 0 while reset high.

## Timing
- Transfer at edge T -> out_valid high for the cycle after edge T+2 (latency 2).
- Aggregate throughput 1 sample/cycle; any single channel can sustain 1 sample/cycle when alone.
- out_valid held one cycle per qualifying sample; out_data/out_channel hold last value otherwise.
- First out_valid for a channel on its WINDOW_SIZE-th accepted sample since reset/clear.
- enable falling: in_ready drops same cycle; up to two in-flight results still emerge.
- Reset asserted mid-operation: in-flight samples dropped, no out_valid after the reset edge.

## Test plan
- Single channel 0, WINDOW_SHIFT=4, constant 100 for 20 samples -> no out_valid for samples 1-15; out_valid on 16th and later with out_data=100, out_channel=0, latency 2.
- All four channels valid continuously with constants 10,20,-30,40 -> grants cycle 0,1,2,3,0...; after 16 samples each, outputs interleave 10,20,-30,40 at 1/cycle.
- Channel 1 ramp 0..31 -> after 16th sample out_data=7 (sum 120>>4); after 32nd out_data=23 (sum 376>>4).
- Negative rounding: channel 2 fed 15 x 0 then -1 -> out_data = -1 (floor), not 0.
- ch_clear[3] pulsed while channel 3 sample is in stage 1 -> that result not emitted; next 16 samples of 50 yield first out_valid on 16th with 50; other channels unaffected.
- Reset asserted with pipeline full -> out_valid 0 next cycle, in_ready 0 during reset, channel 0 granted first afterwards, averaging restarts from empty.
